fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter: BITWID, default 5, width of the data word.
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 fifo_empty  input  1  empty flag from the FIFO read side.
REQ-005 fifo_rd_en  output  1  read request to the FIFO.
REQ-006 fifo_rd_data  input  BITWID  FIFO read data, valid one cycle after fifo_rd_en.
REQ-007 fifo_rd_data_vld  input  1  FIFO read-data valid, high one cycle after an accepted read.
REQ-008 m_valid  output  1  stream data valid.
REQ-009 m_ready  input  1  stream sink ready.
REQ-010 m_data  output  BITWID  stream data.
REQ-011 ovf_err  output  1  sticky flag: return data arrived with no buffer space.
REQ-012 beat_cnt  output  16  accepted-beat counter; this port exists only when FIFO_RD_STREAM_CNT_EN is defined.

Function
REQ-013 The block converts the FIFO's 1-cycle-latency read port into a valid/ready stream with no bubbles, using a 2-entry internal skid buffer.
REQ-014 Buffer: 2 entries, 1-bit write/read pointers wrapping 1->0, 2-bit occupancy buf_cnt in 0..2.
REQ-015 pop = m_valid && m_ready; push = fifo_rd_data_vld.
REQ-016 committed = buf_cnt + push - pop, evaluated each cycle.
REQ-017 fifo_rd_en = rst_n && !fifo_empty && (committed < 2), combinational.
REQ-018 On push, fifo_rd_data is written at the write pointer at the clock edge.
REQ-019 Simultaneous push and pop: buf_cnt is unchanged and both pointers advance.
REQ-020 On a push with buf_cnt==2 and no pop: data is dropped, buf_cnt stays 2, and ovf_err is set until reset.
REQ-021 m_valid = (buf_cnt != 0); m_data = entry at the read pointer; m_data is stable while m_valid && !m_ready.
REQ-022 Latency: if fifo_empty falls in cycle t with the buffer empty, fifo_rd_en is high in t, the data arrives in t+1, and m_valid is high in t+2.
REQ-023 Throughput: with the source non-empty and m_ready held high, m_valid and fifo_rd_en stay high every cycle.
REQ-024 With m_ready low, at most 2 reads are outstanding plus buffered, and fifo_rd_en falls once committed reaches 2.
REQ-025 Stream data order equals FIFO read order; no word is duplicated or lost.

Reset
REQ-026 While rst_n is low at a clock edge: buf_cnt=0, pointers=0, ovf_err=0, beat_cnt=0 (if present).
REQ-027 While rst_n is low: fifo_rd_en=0 and m_valid=0; data in flight when reset is asserted mid-operation is discarded.
REQ-028 The first fifo_rd_en after reset release occurs in the first cycle with rst_n high and fifo_empty low.

Configuration
REQ-029 Macro FIFO_RD_STREAM_CNT_EN defined: beat_cnt increments by 1 on every pop and wraps 0xFFFF->0x0000.
REQ-030 Macro FIFO_RD_STREAM_CNT_EN undefined: the beat_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-031 Reset then fifo_empty=0 at cycle 0 with m_ready=1 and words 0x01,0x02,0x03 -> fifo_rd_en high at cycles 0-2; m_valid high at cycles 2-4 with m_data 0x01,0x02,0x03.
REQ-032 Continuous source with m_ready=0 from cycle 0 -> exactly 2 read pulses, fifo_rd_en low thereafter, buf_cnt=2, ovf_err=0; m_ready=1 -> words drain in order, reads resume the same cycle.
REQ-033 m_ready toggling 1,0,1,0 with a 10-word source -> 10 words out in order, m_data stable on every stalled cycle, ovf_err=0.
REQ-034 Force fifo_rd_data_vld=1 with buf_cnt=2 and m_ready=0 -> ovf_err=1 next cycle and remains 1 until rst_n low.
REQ-035 Assert rst_n=0 for 1 cycle with 2 words buffered -> m_valid=0 and fifo_rd_en=0 the next cycle, and no old word ever appears on m_data.
REQ-036 With FIFO_RD_STREAM_CNT_EN defined: preload beat_cnt to 0xFFFE and do 3 pops -> beat_cnt reads 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready stream bundle.
// master = the converter block, slave = FIFO/sink side.
interface fifo_rd_stream_if #(
  parameter int BITWID = 5
) ();
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [BITWID-1:0] fifo_rd_data;
  logic              fifo_rd_data_vld;
  logic              m_valid;
  logic              m_ready;
  logic [BITWID-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  fifo_rd_data_vld,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output fifo_rd_data_vld,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: 1-cycle-latency FIFO read port to bubble-free stream.
// Define FIFO_RD_STREAM_CNT_EN to add the 16-bit beat_cnt port.
module fifo_rd_stream #(
  parameter int BITWID = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_rd_stream_if.master bus,
  output logic             ovf_err
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]      beat_cnt
`endif
);

  logic [BITWID-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        buf_cnt;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_ok;
  logic [2:0]        committed;

  // Stream outputs and read request; reads stop once 2 words are owed.
  always_comb begin
    bus.m_valid    = rst_n && (buf_cnt != 2'd0);
    bus.m_data     = mem[rd_ptr];
    pop            = bus.m_valid && bus.m_ready;
    push           = bus.fifo_rd_data_vld;
    full           = (buf_cnt == 2'd2);
    wr_ok          = push && (!full || pop);
    committed      = {1'b0, buf_cnt} + {2'b0, push} - {2'b0, pop};
    bus.fifo_rd_en = rst_n && !bus.fifo_empty && (committed < 3'd2);
  end

  // Skid buffer storage; a full buffer with no pop drops the word.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.fifo_rd_data;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      unique case ({wr_ok, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
      if (push && full && !pop) begin
        ovf_err <= 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  // Accepted-beat counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= 16'd0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and random checks of fifo_rd_stream.
// Source FIFO and sink are modelled here; order checked by a queue.
module tb_fifo_rd_stream;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ovf_err;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] beat_cnt;
`endif

  fifo_rd_stream_if #(.BITWID(W)) bus ();

  fifo_rd_stream #(.BITWID(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf_err (ovf_err)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int npop = 0;
  logic hold_empty = 1'b0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] src [$];
  logic [W-1:0] exp_q [$];
  logic rd_tr [256];
  logic mv_tr [256];
  logic [W-1:0] md_tr [256];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic feed_word(input logic [W-1:0] w);
    src.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = hold_empty || (src.size() == 0);
  endtask

  // One clock cycle: sample, check stalls, clock, then act as FIFO/sink.
  task automatic cyc();
    logic rd, mv, rdy;
    logic [W-1:0] d;
    #1;
    rd  = bus.fifo_rd_en;
    mv  = bus.m_valid;
    rdy = bus.m_ready;
    d   = bus.m_data;
    if (t < 256) begin
      rd_tr[t] = rd;
      mv_tr[t] = mv;
      md_tr[t] = d;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(mv), 32'd1);
      chk("stall_data", 32'(d), 32'(prev_data));
    end
    prev_stall = mv && !rdy;
    prev_data  = d;
    @(posedge clk);
    #1;
    t++;
    if (mv && rdy) begin
      npop++;
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("order", 32'(d), 32'(exp_q.pop_front()));
    end
    if (rd && src.size() != 0) begin
      bus.fifo_rd_data     = src.pop_front();
      bus.fifo_rd_data_vld = 1'b1;
    end else begin
      if (rd) chk("read_while_empty", 32'(src.size()), 32'd1);
      bus.fifo_rd_data     = W'($urandom);
      bus.fifo_rd_data_vld = 1'b0;
    end
    bus.fifo_empty = hold_empty || (src.size() == 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    prev_stall = 1'b0;
    src.delete();
    exp_q.delete();
    npop = 0;
    bus.fifo_empty = 1'b0;
    #1;
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < n; i++) cyc();
    chk("rst_ovf", 32'(ovf_err), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("rst_beat", 32'(beat_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    t = 0;
  endtask

  initial begin
    int pulses;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;
    bus.fifo_rd_data_vld = 1'b0;
    bus.m_ready = 1'b0;

    // Basic latency: 3 words, sink always ready
    do_reset(3);
    bus.m_ready = 1'b1;
    feed_word(5'h01);
    feed_word(5'h02);
    feed_word(5'h03);
    repeat (7) cyc();
    chk("lat_rd0", 32'(rd_tr[0]), 32'd1);
    chk("lat_rd1", 32'(rd_tr[1]), 32'd1);
    chk("lat_rd2", 32'(rd_tr[2]), 32'd1);
    chk("lat_rd3", 32'(rd_tr[3]), 32'd0);
    chk("lat_mv1", 32'(mv_tr[1]), 32'd0);
    chk("lat_mv2", 32'(mv_tr[2]), 32'd1);
    chk("lat_md2", 32'(md_tr[2]), 32'h01);
    chk("lat_md3", 32'(md_tr[3]), 32'h02);
    chk("lat_md4", 32'(md_tr[4]), 32'h03);
    chk("lat_mv4", 32'(mv_tr[4]), 32'd1);
    chk("lat_mv5", 32'(mv_tr[5]), 32'd0);
    chk("lat_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: sink stalled, exactly 2 reads outstanding
    do_reset(1);
    bus.m_ready = 1'b0;
    for (int i = 8; i < 16; i++) feed_word(W'(i));
    repeat (8) cyc();
    pulses = 0;
    for (int i = 0; i < 8; i++) if (rd_tr[i]) pulses++;
    chk("bp_pulses", 32'(pulses), 32'd2);
    chk("bp_rd_low", 32'(rd_tr[7]), 32'd0);
    chk("bp_buf_cnt", 32'(dut.buf_cnt), 32'd2);
    chk("bp_ovf", 32'(ovf_err), 32'd0);
    chk("bp_md", 32'(md_tr[7]), 32'h08);
    bus.m_ready = 1'b1;
    cyc();
    chk("bp_resume", 32'(rd_tr[8]), 32'd1);
    repeat (15) cyc();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Alternating ready with 10 words
    do_reset(1);
    for (int i = 16; i < 26; i++) feed_word(W'(i));
    for (int i = 0; i < 30; i++) begin
      bus.m_ready = (i % 2 == 0);
      cyc();
    end
    chk("alt_drained", 32'(exp_q.size()), 32'd0);
    chk("alt_ovf", 32'(ovf_err), 32'd0);

    // Throughput: no bubbles with ready held high
    do_reset(1);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) feed_word(W'(i * 3));
    repeat (24) cyc();
    for (int i = 0; i < 20; i++) chk("tp_rd", 32'(rd_tr[i]), 32'd1);
    for (int i = 2; i < 22; i++) chk("tp_mv", 32'(mv_tr[i]), 32'd1);
    chk("tp_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: forced return data into a full buffer
    do_reset(1);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) feed_word(W'(i + 4));
    repeat (5) cyc();
    chk("ovf_pre", 32'(ovf_err), 32'd0);
    bus.fifo_rd_data_vld = 1'b1;
    bus.fifo_rd_data = 5'h1f;
    cyc();
    chk("ovf_set", 32'(ovf_err), 32'd1);
    repeat (3) cyc();
    chk("ovf_hold", 32'(ovf_err), 32'd1);
    bus.m_ready = 1'b1;
    repeat (12) cyc();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    do_reset(1);

    // Mid-operation reset with 2 words buffered
    bus.m_ready = 1'b0;
    for (int i = 10; i < 14; i++) feed_word(W'(i));
    repeat (4) cyc();
    chk("mr_full", 32'(bus.m_valid), 32'd1);
    do_reset(1);
    #1;
    chk("mr_mv_after", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b1;
    feed_word(5'h15);
    feed_word(5'h16);
    feed_word(5'h17);
    repeat (8) cyc();
    chk("mr_mv0", 32'(mv_tr[0]), 32'd0);
    chk("mr_md2", 32'(md_tr[2]), 32'h15);
    chk("mr_drained", 32'(exp_q.size()), 32'd0);

    // Random source gaps and random backpressure
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      hold_empty = ($urandom_range(0, 3) == 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      if (src.size() < 4 && $urandom_range(0, 2) != 0) feed_word(W'($urandom));
      bus.fifo_empty = hold_empty || (src.size() == 0);
      cyc();
    end
    hold_empty = 1'b0;
    bus.fifo_empty = (src.size() == 0);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_ovf", 32'(ovf_err), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("rnd_beat", 32'(beat_cnt), 32'(npop[15:0]));

    // Beat counter wrap
    begin
      logic [15:0] bexp [3];
      bexp = '{16'hFFFF, 16'h0000, 16'h0001};
      do_reset(1);
      bus.m_ready = 1'b1;
      for (int k = 0; k < 70000 && npop < 65534; k++) begin
        while (src.size() < 6) feed_word(W'(k));
        cyc();
      end
      bus.m_ready = 1'b0;
      chk("cnt_npop", 32'(npop), 32'd65534);
      chk("cnt_pre", 32'(beat_cnt), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
        cyc();
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        chk("cnt_wrap", 32'(beat_cnt), 32'(bexp[k]));
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
